// File: rtl/mux_nx1_pipe.sv
// N-input, one-output registered select with valid/ready handshake.
// A one-entry output register plus a one-entry skid register give full
// throughput under backpressure; in_ready is a flop so there is no
// combinational path from out_ready back to the upstream stage.
module mux_nx1_pipe #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NUM_IN   = 3,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned OOR_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic             in_ready_q, in_ready_d;

  logic             sel_ok;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             accept;
  logic             give;

  // Decode the select; codes at or above NUM_IN leave sel_ok low.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
    res_err  = ~sel_ok;
    if (sel_ok) begin
      res_data = sel_data;
    end else if (OOR_MODE == 1) begin
      res_data = last_good_q;
    end else begin
      res_data = '0;
    end
  end

  assign accept = in_valid & in_ready_q;
  assign give   = out_valid_q & out_ready;

  // Next-state for the output register, skid register and last_good.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    last_good_d  = last_good_q;

    if (give) begin
      if (skid_valid_q) begin
        // Drain the skid; in_ready is low so no accept can coincide.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (accept) begin
      if (!out_valid_q || give) begin
        out_valid_d = 1'b1;
        out_data_d  = res_data;
        out_err_d   = res_err;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = res_data;
        skid_err_d   = res_err;
      end
      if (sel_ok) begin
        last_good_d = sel_data;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      last_good_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      last_good_q  <= last_good_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_sel_err = out_err_q;
  assign out_valid   = out_valid_q;

endmodule
